module_keypad_scan: RTL
=======================

// Module: module_keypad_scan
// PURPOSE
//  Scans a 4x4 matrix keypad and produces the 4-bit key code "sample" consumed by module_suma.
//  Drives one active-low column at a time and reads the 4 pulled-up rows through a 2-flop synchronizer.
//  Debounces press and release, and reports each accepted press exactly once via key_valid.
//  Sits between the board keypad pins and the BCD accumulation logic (27 MHz system clock).
// PARAMETERS
//  SCAN_TICKS  27_000  clk cycles each column is driven (1 ms at 27 MHz); min 4
//  DB_TICKS    270_000 consecutive stable cycles required to accept a press or a release (10 ms)
// PORTS
//  clk        in   1  system clock; all logic on rising edge
//  rst_n      in   1  asynchronous, active-low reset
//  row_in     in   4  keypad rows, active-low (external pull-ups); asynchronous to clk
//  col_out    out  4  keypad column drive, active-low one-hot (exactly one bit 0 at all times)
//  sample     out  4  code of debounced held key; 4'hF when no key held
//  key_valid  out  1  one-cycle strobe, high in the first cycle sample shows a newly accepted key
//  key_held   out  1  high from the key_valid cycle until the release is accepted
// BEHAVIOUR
//  Reset (async assert, sync deassert on clk):
//   - col_out=4'b1110, sample=4'hF, key_valid=0, key_held=0.
//   - Synchronizer flops=4'hF, state=SCAN, all counters=0.
//  Synchronizer: row_s = row_in delayed 2 clk. All decisions use row_s only.
//  Key map (row r, col c), code:
//   - r0: 1 2 3 A
//   - r1: 4 5 6 B
//   - r2: 7 8 9 C
//   - r3: *=E 0=0 #=F D
//   - '#' reports 4'hF; key_valid is the only way to distinguish '#' from idle.
//  Valid pattern: row_s has exactly one bit 0. 4'hF or multiple zeros count as "no key".
//  FSM:
//   - SCAN:
//     - tick counter runs 0..SCAN_TICKS-1.
//     - On the last cycle of a slot, if row_s is valid: latch row_s and the column index, go to DEBOUNCE, keep col_out.
//     - Otherwise rotate col_out left (1110->1101->1011->0111->1110) and restart the counter.
//   - DEBOUNCE:
//     - col_out frozen. Each cycle row_s==latched: counter++; else back to SCAN with the column rotated.
//     - Counter reaches DB_TICKS: go to PRESSED. Next cycle: sample=code, key_valid=1 for one cycle, key_held=1.
//   - PRESSED:
//     - col_out frozen, sample held.
//     - Release counter counts consecutive cycles with row_s==4'hF; any other value clears it.
//     - A second key pressed in the same column (multi-zero) is ignored; it only clears the counter.
//     - Release counter reaches DB_TICKS: sample=4'hF and key_held=0 next cycle, go to SCAN.
//       Rotate the column and restart the slot counter.
//  No auto-repeat: a held key produces exactly one key_valid.
//  Keys in other columns are invisible while a key is held.
//  Reset mid-debounce or mid-press: everything returns to reset values immediately.
//   If the key is still held after reset, it is re-detected and strobed once more after full debounce.
//  Counters are sized $clog2(max(SCAN_TICKS,DB_TICKS)+1). No wrap is possible, because every counter is cleared on state change.
// TESTING
//  Bench: SCAN_TICKS=4, DB_TICKS=8, 37 ns clk.
//  Keypad model: row_in[r] = ~(press[r][c] & ~col_out[c]) over all c.
//  1) Reset, no keys.
//     -> col_out=1110, sample=F, key_valid=0.
//     -> col_out sequence 1110,1101,1011,0111,1110, each held exactly 4 clk.
//  2) Press '9' (r2,c2) for 200 clk, then release.
//     -> exactly one key_valid pulse; sample=9 and key_held=1 from that cycle.
//     -> sample=F, key_held=0 exactly 2+8+1 clk after release.
//  3) Bounce '5': row toggles every 3 clk for 30 clk, then released.
//     -> key_valid never asserts; sample stays F.
//  4) Press '1' and '7' together (same column c0).
//     -> no key_valid.
//     -> Press '3' alone, then add '6' while held: one key_valid (sample=3); no second strobe.
//  5) Press '#', release, then press '*'.
//     -> key_valid with sample=F; then key_valid with sample=E.
//     -> Each pulse 1 clk wide.
//  6) Hold '0', assert rst_n=0 mid-PRESSED for 3 clk.
//     -> outputs at reset values during reset.
//     -> After reset, one new key_valid with sample=0 once the key is re-scanned and debounced.

Source files
------------

// File: rtl/module_keypad_scan.sv
// 4x4 matrix keypad scanner: rotates an active-low column strobe, synchronizes the rows,
// debounces press and release, and emits one key_valid strobe per accepted key.
`timescale 1ns/1ps
module module_keypad_scan #(
  parameter int SCAN_TICKS = 27_000,
  parameter int DB_TICKS   = 270_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] sample,
  output logic       key_valid,
  output logic       key_held
);

  localparam int MAX_TICKS = (SCAN_TICKS > DB_TICKS) ? SCAN_TICKS : DB_TICKS;
  localparam int CW        = $clog2(MAX_TICKS + 1);
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_TICKS - 1);
  localparam logic [CW-1:0] DB_DONE   = CW'(DB_TICKS);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED} state_t;

  state_t        state, state_d;
  logic [3:0]    sync1, row_s;
  logic [3:0]    row_lat, row_lat_d;
  logic [1:0]    col_idx, col_idx_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [3:0]    sample_d;
  logic          kv_d, kh_d;
  logic          row_ok;

  // Exactly one row pulled low; idle or multi-key rows are rejected.
  assign row_ok = (row_s != 4'hF) && (((~row_s) & ((~row_s) - 4'd1)) == 4'd0);

  always_comb col_out = ~(4'b0001 << col_idx);

  function automatic logic [3:0] key_code(input logic [3:0] row, input logic [1:0] col);
    logic [1:0] r;
    case (row)
      4'b1110: r = 2'd0;
      4'b1101: r = 2'd1;
      4'b1011: r = 2'd2;
      default: r = 2'd3;
    endcase
    case ({r, col})
      4'h0: key_code = 4'h1;
      4'h1: key_code = 4'h2;
      4'h2: key_code = 4'h3;
      4'h3: key_code = 4'hA;
      4'h4: key_code = 4'h4;
      4'h5: key_code = 4'h5;
      4'h6: key_code = 4'h6;
      4'h7: key_code = 4'hB;
      4'h8: key_code = 4'h7;
      4'h9: key_code = 4'h8;
      4'hA: key_code = 4'h9;
      4'hB: key_code = 4'hC;
      4'hC: key_code = 4'hE;
      4'hD: key_code = 4'h0;
      4'hE: key_code = 4'hF;
      default: key_code = 4'hD;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= '1;
      row_s     <= '1;
      state     <= SCAN;
      cnt       <= '0;
      row_lat   <= '1;
      col_idx   <= '0;
      sample    <= 4'hF;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      sync1     <= row_in;
      row_s     <= sync1;
      state     <= state_d;
      cnt       <= cnt_d;
      row_lat   <= row_lat_d;
      col_idx   <= col_idx_d;
      sample    <= sample_d;
      key_valid <= kv_d;
      key_held  <= kh_d;
    end
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    row_lat_d = row_lat;
    col_idx_d = col_idx;
    sample_d  = sample;
    kv_d      = 1'b0;
    kh_d      = key_held;
    case (state)
      SCAN: begin
        if (cnt == SCAN_LAST) begin
          cnt_d = '0;
          if (row_ok) begin
            state_d   = DEBOUNCE;
            row_lat_d = row_s;
          end else begin
            col_idx_d = col_idx + 2'd1;
          end
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      DEBOUNCE: begin
        if (cnt == DB_DONE) begin
          state_d  = PRESSED;
          cnt_d    = '0;
          sample_d = key_code(row_lat, col_idx);
          kv_d     = 1'b1;
          kh_d     = 1'b1;
        end else if (row_s == row_lat) begin
          cnt_d = cnt + CW'(1);
        end else begin
          state_d   = SCAN;
          cnt_d     = '0;
          col_idx_d = col_idx + 2'd1;
        end
      end
      PRESSED: begin
        // Only an all-high row counts toward release; a second key in this column just restarts it.
        if (cnt == DB_DONE) begin
          state_d   = SCAN;
          cnt_d     = '0;
          sample_d  = 4'hF;
          kh_d      = 1'b0;
          col_idx_d = col_idx + 2'd1;
        end else if (row_s == 4'hF) begin
          cnt_d = cnt + CW'(1);
        end else begin
          cnt_d = '0;
        end
      end
      default: state_d = SCAN;
    endcase
  end

endmodule
